slot_scheduler: RTL and testbench
=================================

Name: slot_scheduler

Overview:
- Time-slot scheduler in the clock1M domain, driven by the divider's clk_100KHz and clk_10KHz outputs.
- Each rising edge of clk_100KHz opens one service slot; one slot is 10 clock1M cycles.
- Each slot is granted to at most one of N_REQ requesters, round-robin, with a req/grant/done handshake and a timeout at the next slot.
- Each rising edge of clk_10KHz starts a frame of 10 slots and restores the priority order.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SLOTS_PER_FRAME, 10, slots per clk_10KHz period; slot_idx wraps at this value.
- CNT_W, 8, width of the saturating timeout counter.

Ports:
- clock1M  in  1  system clock, 1 MHz.
- reset  in  1  synchronous, active-high.
- clk_100KHz  in  1  divider output, generated in the clock1M domain; sampled directly, no synchroniser.
- clk_10KHz  in  1  divider output, generated in the clock1M domain.
- req  in  N_REQ  per-requester service request, level.
- done  in  N_REQ  completion strobe; only the bit of the granted requester is observed.
- grant  out  N_REQ  one-hot grant, registered.
- grant_id  out  $clog2(N_REQ)  index of the current or last grant.
- busy  out  1  high while a grant is held.
- slot_idx  out  4  current slot number in the frame, 0..SLOTS_PER_FRAME-1.
- frame_start  out  1  one-cycle pulse on a frame tick.
- timeout  out  1  one-cycle pulse when a grant is revoked without done.
- timeout_count  out  CNT_W  saturating count of timeouts.

Behaviour:
- Clock and reset: one clock (clock1M); reset is synchronous and active-high.
- Reset values:
  - grant=0, grant_id=0, busy=0, slot_idx=0, frame_start=0, timeout=0, timeout_count=0.
  - RR pointer=N_REQ-1, so the first search starts at requester 0.
  - Edge registers c100_q=1 and c10_q=1, so a line already high at reset release gives no tick.
- Edge detect:
  - slot_tick = clk_100KHz & ~c100_q.
  - frame_tick = clk_10KHz & ~c10_q.
  - Both are combinational, valid in the first cycle the line is sampled high.
- Slot index:
  - frame_tick: slot_idx<=0 and frame_start<=1 next cycle.
  - slot_tick without frame_tick: slot_idx<=slot_idx+1, wrapping SLOTS_PER_FRAME-1 -> 0.
  - frame_tick also resets the RR pointer to N_REQ-1.
- FSM, states IDLE and GRANT:
  - IDLE, on slot_tick with req!=0:
    - Pick the first set req bit searching from pointer+1 upward, with wrap.
    - Next cycle: grant=onehot(pick), grant_id=pick, busy=1, state=GRANT.
    - Grant latency is exactly 1 cycle after slot_tick.
  - IDLE, slot_tick with req==0: no grant; the slot is lost.
  - GRANT, done[grant_id]=1:
    - Next cycle: grant=0, busy=0, pointer<=grant_id, state=IDLE.
    - No second grant within the same slot.
  - GRANT, slot_tick without done:
    - Next cycle: grant=0, busy=0, timeout=1, timeout_count+=1 (saturating at all-ones), pointer<=grant_id, state=IDLE.
    - The tick is consumed; no arbitration on it.
  - GRANT, done and slot_tick in the same cycle: counts as completion, no timeout; the tick is consumed.
  - GRANT, req[grant_id] dropped: grant is held anyway (req is not rechecked until done or timeout).
- Simultaneous frame_tick and slot_tick in IDLE: pointer is treated as N_REQ-1 for this arbitration, so priority starts at requester 0.
- done bits of non-granted requesters are ignored in all states.
- Reset mid-grant: every output returns to its reset value at the next edge.

Decomposition:
- Package sched_pkg:
  - state enum {IDLE, GRANT}.
  - SLOTS_PER_FRAME=10 and default N_REQ=4.
  - Function onehot_of(idx).
- Sub-module rr_pick:
  - Purely combinational round-robin search.
  - Inputs: req, ptr. Outputs: pick idx, valid.
  - Reused by other arbiters.

Test Plan:
- Reset release with clk_100KHz already high -> no grant until its next rising edge; slot_idx=0, grant=0.
- req=4'b1111, each requester asserts done 3 cycles after its grant:
  - Grants cycle req0, req1, req2, req3, req0 over 5 consecutive slots.
  - Each grant appears 1 cycle after slot_tick.
  - Grants are 10 cycles apart.
- req=4'b0100 and requester 2 never asserts done:
  - grant=4'b0100 held for 10 cycles, then timeout pulses for 1 cycle; timeout_count=1.
  - The next grant comes one slot later.
  - After 300 such timeouts, timeout_count stays 8'hFF.
- req=4'b1010, pointer at 1, frame_tick coinciding with slot_tick -> grant=4'b0010 (priority reset to 0); frame_start pulses; slot_idx=0.
- 100 clock1M cycles of free run -> slot_idx steps 0..9 and wraps to 0 on each frame_tick; frame_start has period 100 cycles.
- reset asserted while grant=4'b0001 -> grant=0, busy=0, slot_idx=0 next cycle; afterwards the first grant goes to the lowest set req bit.

Source files
------------

// File: rtl/slot_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg: shared types and helpers for the slot scheduler and its arbiters.
//   state_t                  - scheduler FSM states (IDLE, GRANT)
//   N_REQ_DEFAULT            - default number of requesters
//   SLOTS_PER_FRAME_DEFAULT  - default slots per frame
//   MAX_REQ                  - largest supported requester count
//   onehot_of(idx)           - MAX_REQ-wide one-hot vector with bit idx set
// -----------------------------------------------------------------------------
package sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned N_REQ_DEFAULT           = 4;
  localparam int unsigned SLOTS_PER_FRAME_DEFAULT = 10;
  localparam int unsigned MAX_REQ                 = 8;

  function automatic logic [MAX_REQ-1:0] onehot_of(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/slot_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick: combinational round-robin search.
// Finds the first set bit of i_req starting at i_ptr+1 and wrapping around,
// so the requester at i_ptr has the lowest priority.
//   i_req   [N-1:0]      request vector
//   i_ptr   [IDX_W-1:0]  index of the most recently served requester
//   o_pick  [IDX_W-1:0]  index of the selected requester (0 when none)
//   o_valid              at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_pick,
  output logic             o_valid
);

  always_comb begin : search
    logic [IDX_W-1:0] idx;
    idx     = '0;
    o_pick  = '0;
    o_valid = 1'b0;
    // Walk offsets from farthest to nearest: the nearest set bit after the
    // pointer is written last and therefore wins.
    for (int unsigned k = N; k >= 1; k--) begin
      idx = IDX_W'((32'(i_ptr) + k) % N);
      if (i_req[idx]) begin
        o_pick  = idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slot_scheduler.sv
// -----------------------------------------------------------------------------
// slot_scheduler: time-slot round-robin scheduler in the clock1M domain.
// A rising clk_100KHz opens a slot that is granted to at most one requester;
// a rising clk_10KHz starts a frame and restores requester 0 as top priority.
// A grant ends on done from the granted requester or is revoked (timeout) on
// the next slot tick.
//   clock1M        system clock
//   reset          synchronous, active-high
//   clk_100KHz     slot tick line (same clock domain, no synchroniser)
//   clk_10KHz      frame tick line (same clock domain)
//   req            per-requester level request
//   done           completion strobe, only the granted bit is observed
//   grant          registered one-hot grant
//   grant_id       index of the current or last grant
//   busy           a grant is held
//   slot_idx       slot number within the frame
//   frame_start    one-cycle pulse per frame tick
//   timeout        one-cycle pulse when a grant is revoked without done
//   timeout_count  saturating timeout counter
// -----------------------------------------------------------------------------
module slot_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned N_REQ           = N_REQ_DEFAULT,
  parameter int unsigned SLOTS_PER_FRAME = SLOTS_PER_FRAME_DEFAULT,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                     clock1M,
  input  logic                     reset,
  input  logic                     clk_100KHz,
  input  logic                     clk_10KHz,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [3:0]               slot_idx,
  output logic                     frame_start,
  output logic                     timeout,
  output logic [CNT_W-1:0]         timeout_count
);

  localparam int unsigned     ID_W      = $clog2(N_REQ);
  localparam logic [ID_W-1:0] PTR_RST   = ID_W'(N_REQ - 1);
  localparam logic [3:0]      SLOT_LAST = 4'(SLOTS_PER_FRAME - 1);

  state_t            r_state;
  logic              r_c100_q;
  logic              r_c10_q;
  logic [ID_W-1:0]   r_ptr;
  logic [N_REQ-1:0]  r_grant;
  logic [ID_W-1:0]   r_grant_id;
  logic              r_busy;
  logic [3:0]        r_slot_idx;
  logic              r_frame_start;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_timeout_count;

  logic              w_slot_tick;
  logic              w_frame_tick;
  logic [ID_W-1:0]   w_arb_ptr;
  logic [ID_W-1:0]   w_pick;
  logic              w_pick_valid;
  logic              w_done_granted;

  assign w_slot_tick    = clk_100KHz & ~r_c100_q;
  assign w_frame_tick   = clk_10KHz & ~r_c10_q;
  // A frame tick restores priority for the arbitration in the same cycle.
  assign w_arb_ptr      = w_frame_tick ? PTR_RST : r_ptr;
  assign w_done_granted = done[r_grant_id];

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .i_req   (req),
    .i_ptr   (w_arb_ptr),
    .o_pick  (w_pick),
    .o_valid (w_pick_valid)
  );

  always_ff @(posedge clock1M) begin
    if (reset) begin
      r_c100_q        <= 1'b1;
      r_c10_q         <= 1'b1;
      r_state         <= IDLE;
      r_ptr           <= PTR_RST;
      r_grant         <= '0;
      r_grant_id      <= '0;
      r_busy          <= 1'b0;
      r_slot_idx      <= '0;
      r_frame_start   <= 1'b0;
      r_timeout       <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_c100_q      <= clk_100KHz;
      r_c10_q       <= clk_10KHz;
      r_frame_start <= w_frame_tick;
      r_timeout     <= 1'b0;

      if (w_frame_tick) begin
        r_slot_idx <= '0;
      end else if (w_slot_tick) begin
        r_slot_idx <= (r_slot_idx == SLOT_LAST) ? '0 : r_slot_idx + 4'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_slot_tick && w_pick_valid) begin
            r_grant    <= N_REQ'(onehot_of(3'(w_pick)));
            r_grant_id <= w_pick;
            r_busy     <= 1'b1;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          // done wins over a coincident slot tick; either way the tick is
          // consumed and the next arbitration waits for the following slot.
          if (w_done_granted) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_grant_id;
            r_state <= IDLE;
          end else if (w_slot_tick) begin
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= r_grant_id;
            r_timeout <= 1'b1;
            if (r_timeout_count != '1) begin
              r_timeout_count <= r_timeout_count + 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Frame restart overrides any pointer update from a completion.
      if (w_frame_tick) begin
        r_ptr <= PTR_RST;
      end
    end
  end

  assign grant         = r_grant;
  assign grant_id      = r_grant_id;
  assign busy          = r_busy;
  assign slot_idx      = r_slot_idx;
  assign frame_start   = r_frame_start;
  assign timeout       = r_timeout;
  assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_slot_scheduler: self-checking bench for slot_scheduler (N_REQ=4).
// A vector table covers reset and single-slot corner cases cycle by cycle;
// hand-written sequences drive the tick lines from a bench divider for the
// round-robin, timeout/saturation, reset-mid-grant and free-run checks.
// -----------------------------------------------------------------------------
module tb_slot_scheduler;

  logic       clock1M = 1'b0;
  logic       reset;
  logic       clk_100KHz;
  logic       clk_10KHz;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] slot_idx;
  logic       frame_start;
  logic       timeout;
  logic [7:0] timeout_count;

  always #5 clock1M = ~clock1M;

  slot_scheduler #(
    .N_REQ           (4),
    .SLOTS_PER_FRAME (10),
    .CNT_W           (8)
  ) dut (
    .clock1M       (clock1M),
    .reset         (reset),
    .clk_100KHz    (clk_100KHz),
    .clk_10KHz     (clk_10KHz),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .grant_id      (grant_id),
    .busy          (busy),
    .slot_idx      (slot_idx),
    .frame_start   (frame_start),
    .timeout       (timeout),
    .timeout_count (timeout_count)
  );

  typedef struct {
    logic       rst;
    logic       c100;
    logic       c10;
    logic [3:0] rq;
    logic [3:0] dn;
    logic [3:0] g;
    logic [1:0] gid;
    logic [3:0] sidx;
    logic       fs;
    logic       to;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] gid;
    logic       bsy;
    logic [3:0] sidx;
    logic       fs;
    logic       to;
    logic [7:0] cnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [3:0]  sb_g[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned div_cnt = 0;
  int unsigned cy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cy);
    end
  endtask

  task automatic add_vec(input logic rst, input logic c100, input logic c10,
                         input logic [3:0] rq, input logic [3:0] dn,
                         input logic [3:0] g, input logic [1:0] gid,
                         input logic [3:0] sidx, input logic fs,
                         input logic to, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.c100 = c100; v.c10 = c10; v.rq = rq; v.dn = dn;
    v.g = g; v.gid = gid; v.sidx = sidx; v.fs = fs; v.to = to; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // One clock with the tick lines taken from the bench divider
  // (clk_100KHz: 10-cycle period, clk_10KHz: 100-cycle period, edges aligned).
  task automatic cyc();
    @(negedge clock1M);
    clk_100KHz = ((div_cnt % 10) < 5);
    clk_10KHz  = (div_cnt < 50);
    div_cnt    = (div_cnt + 1) % 100;
    @(posedge clock1M);
    #1;
    cy++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    exp_t        e;
    exp_t        got;
    int unsigned seen;
    int unsigned held;
    int unsigned last_g;
    int unsigned pushed;
    int unsigned w;
    int unsigned h;
    int unsigned n;
    int unsigned tot;
    int unsigned exp_s;
    int unsigned last_fs;
    int unsigned nfs;
    int unsigned c;
    logic [3:0]  eg;
    bit          prev_tick;
    bit          will;

    reset = 1'b1; clk_100KHz = 1'b1; clk_10KHz = 1'b1; req = 4'h0; done = 4'h0;

    // ---------------- table: rst c100 c10 req done | grant id slot fs to cnt
    add_vec(1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'h1, 2'd0, 4'd1, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 4'h0, 2'd0, 4'd1, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 4'd1, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'h2, 2'd1, 4'd2, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 4'h2, 2'd1, 4'd2, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b0, 1'b0, 4'hF, 4'h2, 4'h0, 2'd1, 4'd2, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 2'd1, 4'd3, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 2'd1, 4'd3, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b0, 4'h4, 4'h0, 4'h4, 2'd2, 4'd4, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h4, 2'd2, 4'd4, 1'b0, 1'b0, 8'd0);
    add_vec(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 2'd2, 4'd5, 1'b0, 1'b1, 8'd1);
    add_vec(1'b0, 1'b1, 1'b0, 4'h4, 4'h0, 4'h0, 2'd2, 4'd5, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0, 2'd2, 4'd5, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b1, 1'b0, 4'hA, 4'h0, 4'h8, 2'd3, 4'd6, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 4'h8, 2'd3, 4'd6, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b1, 1'b0, 4'hA, 4'h8, 4'h0, 2'd3, 4'd7, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0, 2'd3, 4'd7, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b1, 1'b0, 4'hA, 4'h0, 4'h2, 2'd1, 4'd8, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b0, 1'b0, 4'hA, 4'h2, 4'h0, 2'd1, 4'd8, 1'b0, 1'b0, 8'd1);
    add_vec(1'b0, 1'b1, 1'b1, 4'hA, 4'h0, 4'h2, 2'd1, 4'd0, 1'b1, 1'b0, 8'd1);
    add_vec(1'b0, 1'b1, 1'b1, 4'hA, 4'h0, 4'h2, 2'd1, 4'd0, 1'b0, 1'b0, 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clock1M);
      reset = v.rst; clk_100KHz = v.c100; clk_10KHz = v.c10; req = v.rq; done = v.dn;
      e.g = v.g; e.gid = v.gid; e.bsy = |v.g; e.sidx = v.sidx;
      e.fs = v.fs; e.to = v.to; e.cnt = v.cnt;
      sb.push_back(e);
      @(posedge clock1M);
      #1;
      cy++;
      got = sb.pop_front();
      chk($sformatf("vec%0d.grant", i), grant, got.g);
      chk($sformatf("vec%0d.grant_id", i), grant_id, got.gid);
      chk($sformatf("vec%0d.busy", i), busy, got.bsy);
      chk($sformatf("vec%0d.slot_idx", i), slot_idx, got.sidx);
      chk($sformatf("vec%0d.frame_start", i), frame_start, got.fs);
      chk($sformatf("vec%0d.timeout", i), timeout, got.to);
      chk($sformatf("vec%0d.timeout_count", i), timeout_count, got.cnt);
    end

    // ---------------- round robin over req=1111, done 3 cycles after grant
    done = 4'h0; req = 4'hF; div_cnt = 0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    seen = 0; held = 0; last_g = 0; pushed = 0; prev_tick = 1'b0;
    for (int i = 0; i < 80 && seen < 5; i++) begin
      will = ((div_cnt % 10) == 0);
      if (will) begin
        sb_g.push_back(4'(1 << (pushed % 4)));
        pushed++;
      end
      cyc();
      if (prev_tick) begin
        eg = sb_g.pop_front();
        chk("rr_grant", grant, eg);
        if (seen > 0) chk("rr_gap", cy - last_g, 10);
        last_g = cy;
        seen++;
      end
      prev_tick = will;
      if (grant != 4'h0) held++; else held = 0;
      done = (held == 3) ? grant : 4'h0;
    end
    chk("rr_grants_seen", seen, 5);
    sb_g.delete();

    // ---------------- timeout: requester 2 never completes
    done = grant;
    cyc();
    done = 4'h0; req = 4'b0100;
    w = 0;
    while (grant != 4'b0100 && w < 40) begin cyc(); w++; end
    chk("to_grant", grant, 4'b0100);
    h = 0;
    while (grant == 4'b0100 && h < 30) begin h++; cyc(); end
    chk("to_hold_cycles", h, 10);
    chk("to_pulse", timeout, 1);
    chk("to_count1", timeout_count, 1);
    chk("to_busy", busy, 0);
    n = 0;
    do begin
      cyc();
      n++;
      if (n == 1) chk("to_pulse_width", timeout, 0);
    end while (grant == 4'h0 && n < 30);
    chk("to_regrant_gap", n, 10);

    tot = 1;
    for (int i = 0; i < 8000 && tot < 300; i++) begin
      cyc();
      if (timeout) begin
        tot++;
        chk("to_sat", timeout_count, (tot < 255) ? tot : 255);
      end
    end
    chk("to_total", tot, 300);
    chk("to_sat_final", timeout_count, 8'hFF);

    // ---------------- reset while requester 0 holds a grant
    req = 4'b0001;
    w = 0;
    while (grant != 4'b0001 && w < 60) begin cyc(); w++; end
    chk("rst_pre_grant", grant, 4'b0001);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_slot_idx", slot_idx, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_count", timeout_count, 0);
    req = 4'b0110;
    w = 0;
    while (grant == 4'h0 && w < 40) begin cyc(); w++; end
    chk("rst_first_grant", grant, 4'b0010);
    chk("rst_first_id", grant_id, 1);

    // ---------------- free run: slot index and frame pulse
    req = 4'h0; done = 4'h0;
    w = 0;
    while (div_cnt != 55 && w < 200) begin cyc(); w++; end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_s = 0; last_fs = 0; nfs = 0;
    for (int i = 0; i < 250; i++) begin
      c = div_cnt;
      cyc();
      if (c == 0) exp_s = 0;
      else if ((c % 10) == 0) exp_s = (exp_s + 1) % 10;
      chk("free_slot_idx", slot_idx, exp_s);
      chk("free_frame_start", frame_start, (c == 0) ? 1 : 0);
      if (frame_start) begin
        if (nfs > 0) chk("free_frame_period", cy - last_fs, 100);
        last_fs = cy;
        nfs++;
      end
    end
    chk("free_frame_count", nfs, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
